// File: rtl/fp_xfer.sv
// fp_xfer: operand transfer sequencer between micro-sequencer and F-PA.
// Loads T from three W words and streams T back over ZP as 3 or 4 words.
module fp_xfer #(
   parameter bit CLR_T = 1'b1
) (
   input  logic        clk_sys,
   input  logic        rst_,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_op,
   input  logic        cmd_flags,
   input  logic        win_valid,
   output logic        win_ready,
   input  logic [0:15] win_data,
   output logic        wout_valid,
   input  logic        wout_ready,
   output logic [0:15] wout_data,
   input  logic        exp_we,
   input  logic [0:7]  exp_in,
   output logic [0:7]  exp,
   output logic [0:15] w,
   output logic        lkb,
   output logic        f9,
   output logic        opta,
   output logic        optb,
   output logic        optc,
   output logic        taa,
   output logic        tab,
   output logic        trb,
   output logic        strob_fp,
   output logic        _0_t,
   output logic        zpa,
   output logic        zpb,
   output logic        _0_zp,
   input  logic [0:15] zp,
   output logic [0:7]  d,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE, L_CLR, L_W, L_S, S_SEL, S_OUT, DONE
   } state_t;

   state_t     state;
   logic [1:0] idx;
   logic       flg;

   assign cmd_ready = (state == IDLE);
   assign d = exp;

   // Sequencer; every F-PA control line is a registered output.
   always_ff @(posedge clk_sys or negedge rst_) begin
      if (!rst_) begin
         state      <= IDLE;
         idx        <= 2'd0;
         flg        <= 1'b0;
         exp        <= '0;
         w          <= '0;
         wout_data  <= '0;
         opta       <= 1'b0;
         optb       <= 1'b0;
         optc       <= 1'b0;
         strob_fp   <= 1'b0;
         _0_t       <= 1'b0;
         lkb        <= 1'b0;
         f9         <= 1'b0;
         zpa        <= 1'b0;
         zpb        <= 1'b0;
         wout_valid <= 1'b0;
         win_ready  <= 1'b0;
         done       <= 1'b0;
         taa        <= 1'b1;
         tab        <= 1'b1;
         trb        <= 1'b1;
         _0_zp      <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (exp_we) exp <= exp_in;
               if (cmd_valid) begin
                  idx <= 2'd0;
                  flg <= cmd_flags;
                  if (cmd_op) begin
                     state      <= S_SEL;
                     _0_zp      <= 1'b0;
                     {zpb, zpa} <= 2'b00;
                  end else if (CLR_T) begin
                     state <= L_CLR;
                     _0_t  <= 1'b1;
                  end else begin
                     state     <= L_W;
                     win_ready <= 1'b1;
                  end
               end
            end
            L_CLR: begin
               _0_t      <= 1'b0;
               win_ready <= 1'b1;
               state     <= L_W;
            end
            L_W: begin
               if (win_valid && win_ready) begin
                  w               <= win_data;
                  lkb             <= 1'b1;
                  f9              <= 1'b0;
                  {taa, tab, trb} <= 3'b000;
                  opta            <= (idx == 2'd0);
                  optb            <= (idx == 2'd1);
                  optc            <= (idx == 2'd2);
                  if (idx == 2'd2) exp <= win_data[8:15];
                  win_ready       <= 1'b0;
                  strob_fp        <= 1'b1;
                  state           <= L_S;
               end
            end
            L_S: begin
               // T latches on this falling strobe; selects stay put.
               strob_fp <= 1'b0;
               if (idx == 2'd2) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  idx       <= idx + 2'd1;
                  win_ready <= 1'b1;
                  state     <= L_W;
               end
            end
            S_SEL: begin
               if (idx == 2'd2) wout_data <= {zp[0:7], exp};
               else wout_data <= zp;
               _0_zp      <= 1'b1;
               wout_valid <= 1'b1;
               state      <= S_OUT;
            end
            S_OUT: begin
               if (wout_ready) begin
                  wout_valid <= 1'b0;
                  if (idx < 2'd2 || (idx == 2'd2 && flg)) begin
                     idx        <= idx + 2'd1;
                     {zpb, zpa} <= idx + 2'd1;
                     _0_zp      <= 1'b0;
                     state      <= S_SEL;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               done            <= 1'b0;
               opta            <= 1'b0;
               optb            <= 1'b0;
               optc            <= 1'b0;
               lkb             <= 1'b0;
               f9              <= 1'b0;
               {taa, tab, trb} <= 3'b111;
               {zpb, zpa}      <= 2'b00;
               _0_zp           <= 1'b1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_xfer.sv
// tb_fp_xfer: directed vectors for fp_xfer against a small F-PA T model.
// Table-driven load/store traces plus stall, exp_we and reset sequences.
module tb_fp_xfer;

   logic        clk_sys = 1'b0;
   logic        rst_;
   logic        cmd_valid, cmd_ready, cmd_op, cmd_flags;
   logic        win_valid, win_ready;
   logic [0:15] win_data;
   logic        wout_valid, wout_ready;
   logic [0:15] wout_data;
   logic        exp_we;
   logic [0:7]  exp_in, exp;
   logic [0:15] w;
   logic        lkb, f9, opta, optb, optc, taa, tab, trb;
   logic        strob_fp, _0_t, zpa, zpb, _0_zp;
   logic [0:15] zp;
   logic [0:7]  d;
   logic        done;

   int n_run = 0;
   int n_fail = 0;

   logic [0:39] t = '0;
   logic [0:15] flg_word = 16'hA000;
   logic [0:15] lw [0:2];
   int          widx = 0;

   fp_xfer #(.CLR_T(1'b1)) dut (
      .clk_sys(clk_sys), .rst_(rst_),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_flags(cmd_flags),
      .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
      .wout_valid(wout_valid), .wout_ready(wout_ready),
      .wout_data(wout_data),
      .exp_we(exp_we), .exp_in(exp_in), .exp(exp), .w(w),
      .lkb(lkb), .f9(f9), .opta(opta), .optb(optb), .optc(optc),
      .taa(taa), .tab(tab), .trb(trb), .strob_fp(strob_fp),
      ._0_t(_0_t), .zpa(zpa), .zpb(zpb), ._0_zp(_0_zp),
      .zp(zp), .d(d), .done(done)
   );

   always #5 clk_sys = ~clk_sys;

   // F-PA T register: cleared by _0_t, parallel load K=W on strobe fall
   always @(negedge strob_fp or posedge _0_t) begin
      if (_0_t) t = '0;
      else if (rst_ && lkb && !f9 && !taa && !tab && !trb) begin
         if (opta) t[0:15] = w;
         if (optb) t[16:31] = w;
         if (optc) t[32:39] = w[0:7];
      end
   end

   // ZP bus; low byte of word 2 is junk that must be replaced by exp
   always_comb begin
      zp = '0;
      if (!_0_zp) begin
         case ({zpb, zpa})
            2'd0: zp = t[0:15];
            2'd1: zp = t[16:31];
            2'd2: zp = {t[32:39], 8'hC3};
            default: zp = flg_word;
         endcase
      end
   end

   typedef struct {
      logic [8:0]  c;
      logic        chk;
      logic [0:15] wv;
      logic [0:7]  e;
   } lrow_t;

   typedef struct {
      logic [2:0]  c;
      logic [1:0]  zs;
      logic [0:15] dv;
   } srow_t;

   lrow_t lt [0:8];
   srow_t sr [0:6];

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_run++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic step();
      logic hs;
      hs = win_valid && win_ready;
      @(posedge clk_sys);
      #1;
      if (hs && widx < 2) widx++;
      win_data = lw[widx];
   endtask

   task automatic start(input logic op, input logic fl);
      for (int i = 0; i < 10 && !cmd_ready; i++) step();
      chk("cmd_ready before command", cmd_ready, 1);
      cmd_op = op;
      cmd_flags = fl;
      cmd_valid = 1'b1;
      widx = 0;
      win_data = lw[0];
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic store_run(input logic fl, input logic [0:15] e0,
                            input logic [0:15] e1, input logic [0:15] e2,
                            input logic [0:15] e3);
      logic [0:15] ev [0:3];
      logic [1:0]  sl [0:3];
      int nw, ns, nexp;
      bit fin;
      ev = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) sl[i] = 2'bxx;
      nexp = fl ? 4 : 3;
      nw = 0;
      ns = 0;
      fin = 0;
      start(1'b1, fl);
      for (int c = 0; c < 40 && !fin; c++) begin
         if (!_0_zp && ns < 4) begin
            sl[ns] = {zpb, zpa};
            ns++;
         end
         if (done) fin = 1;
         else begin
            wout_ready = fl ? ((c % 3) != 1) : 1'b1;
            if (wout_valid && nw < 4)
               chk($sformatf("store word%0d", nw), wout_data, ev[nw]);
            if (wout_valid && wout_ready) nw++;
            step();
         end
      end
      wout_ready = 1'b1;
      chk("store done seen", fin, 1);
      chk("store word count", nw, nexp);
      chk("store select count", ns, nexp);
      for (int i = 0; i < nexp; i++)
         chk($sformatf("store select%0d", i), sl[i], i);
   endtask

   initial begin
      int k;
      logic dn;

      lt[0] = '{9'b100000010, 1'b1, 16'h0000, 8'h55};
      lt[1] = '{9'b010000010, 1'b1, 16'h0000, 8'h55};
      lt[2] = '{9'b001100100, 1'b1, 16'h4000, 8'h55};
      lt[3] = '{9'b010100100, 1'b1, 16'h4000, 8'h55};
      lt[4] = '{9'b001010100, 1'b1, 16'h1234, 8'h55};
      lt[5] = '{9'b010010100, 1'b1, 16'h1234, 8'h55};
      lt[6] = '{9'b001001100, 1'b1, 16'hAB7F, 8'h7F};
      lt[7] = '{9'b000000011, 1'b0, 16'h0000, 8'h7F};
      lt[8] = '{9'b000000010, 1'b1, 16'h0000, 8'h7F};

      sr[0] = '{3'b000, 2'd0, 16'h0000};
      sr[1] = '{3'b110, 2'd0, 16'h4000};
      sr[2] = '{3'b000, 2'd1, 16'h0000};
      sr[3] = '{3'b110, 2'd0, 16'h1234};
      sr[4] = '{3'b000, 2'd2, 16'h0000};
      sr[5] = '{3'b110, 2'd0, 16'hAB7F};
      sr[6] = '{3'b101, 2'd0, 16'h0000};

      lw = '{16'h4000, 16'h1234, 16'hAB7F};
      rst_ = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = 1'b0;
      cmd_flags = 1'b0;
      win_valid = 1'b1;
      win_data = lw[0];
      wout_ready = 1'b1;
      exp_we = 1'b0;
      exp_in = '0;

      repeat (3) @(posedge clk_sys);
      #1;
      chk("reset cmd_ready", cmd_ready, 1);
      chk("reset ctl low", {opta, optb, optc, strob_fp, _0_t, lkb, f9,
          zpa, zpb, wout_valid, win_ready, done}, 0);
      chk("reset ctl high", {taa, tab, trb, _0_zp}, 4'b1111);
      chk("reset exp", exp, 0);
      chk("reset w", w, 0);
      chk("reset wout_data", wout_data, 0);
      @(negedge clk_sys);
      rst_ = 1'b1;
      step();

      exp_we = 1'b1;
      exp_in = 8'h55;
      step();
      exp_we = 1'b0;
      chk("idle exp_we exp", exp, 8'h55);
      chk("idle exp_we d", d, 8'h55);

      start(1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         if (lt[i].chk)
            chk($sformatf("load c%0d ctl", i + 1),
                {_0_t, win_ready, strob_fp, opta, optb, optc, lkb, taa, done},
                lt[i].c);
         else
            chk($sformatf("load c%0d done", i + 1), done, lt[i].c[0]);
         if (lt[i].c[6]) chk($sformatf("load c%0d w", i + 1), w, lt[i].wv);
         chk($sformatf("load c%0d exp", i + 1), exp, lt[i].e);
         if (i == 2) begin
            exp_we = 1'b1;
            exp_in = 8'h99;
         end
         if (i == 5) exp_we = 1'b0;
         if (i < 8) step();
      end

      start(1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("store c%0d ctl", i + 1),
             {_0_zp, wout_valid, done}, sr[i].c);
         if (!sr[i].c[2])
            chk($sformatf("store c%0d zsel", i + 1), {zpb, zpa}, sr[i].zs);
         if (sr[i].c[1])
            chk($sformatf("store c%0d data", i + 1), wout_data, sr[i].dv);
         if (i < 6) step();
      end

      store_run(1'b1, 16'h4000, 16'h1234, 16'hAB7F, 16'hA000);

      lw = '{16'h1111, 16'h2222, 16'h33C4};
      start(1'b0, 1'b0);
      repeat (4) step();
      chk("pre-reset strobe optb", {strob_fp, optb}, 2'b11);
      rst_ = 1'b0;
      #1;
      chk("abort ctl", {strob_fp, opta, optb, optc, win_ready}, 0);
      chk("abort exp", exp, 0);
      dn = done;
      repeat (3) begin
         step();
         dn = dn | done;
      end
      @(negedge clk_sys);
      rst_ = 1'b1;
      repeat (2) begin
         step();
         dn = dn | done;
      end
      chk("abort no done", dn, 0);
      chk("abort back idle", cmd_ready, 1);

      lw = '{16'h5A5A, 16'h0F0F, 16'hC3E1};
      start(1'b0, 1'b0);
      k = 1;
      while (!done && k < 20) begin
         step();
         k++;
      end
      chk("reload done cycle", k, 8);
      chk("reload exp", exp, 8'hE1);
      chk("reload d", d, 8'hE1);

      store_run(1'b0, 16'h5A5A, 16'h0F0F, 16'hC3E1, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_xfer.md
Name: fp_xfer

Overview:
- Operand transfer sequencer for the F-PA datapath.
- Load: accepts three 16-bit words of a floating-point operand and writes them into T[0:39] over the W/K path, using the per-section T load enables and strob_fp pulses.
- Store: reads T back through the ZP bus, using the zpa/zpb word select, and emits 3 words, or 4 when flags are requested, on a valid/ready stream.
- Holds the 8-bit exponent, drives it onto d[0:7] for the third result word, and sits between the micro-sequencer and F-PA.

Parameters:
CLR_T, 1, when 1 a load begins with a one-cycle _0_t pulse clearing T.

Ports:
clk_sys  in  1  system clock
rst_  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  1  0=load, 1=store
cmd_flags  in  1  store: append flags word
win_valid  in  1  load word valid
win_ready  out  1  load word accepted when valid&ready
win_data  in  [0:15]  load word (bit 0 = MSB)
wout_valid  out  1  store word valid
wout_ready  in  1  store word consumed
wout_data  out  [0:15]  store word
exp_we  in  1  external exponent write
exp_in  in  [0:7]  external exponent value
exp  out  [0:7]  exponent register
w  out  [0:15]  W bus to F-PA
lkb, f9  out  1,1  K-source select, fixed 1,0 (K = W) while loading, else 0,0
opta, optb, optc  out  1 each  T section enables
taa, tab, trb  out  1 each  T op select, 0 = parallel load during load, else 1 (hold)
strob_fp  out  1  F-PA strobe, T latches on falling edge
_0_t  out  1  T clear
zpa, zpb  out  1,1  ZP word select
_0_zp  out  1  ZP bus force-zero
zp  in  [0:15]  ZP bus from F-PA
d  out  [0:7]  equals exp
done  out  1  one-cycle pulse at end of command

Behaviour:
- Reset (rst_ low, asynchronous, any state):
  - state=IDLE, exp=0, w=0, wout_data=0.
  - opta/optb/optc/strob_fp/_0_t/lkb/f9/zpa/zpb/wout_valid/win_ready/done=0.
  - taa/tab/trb=1, _0_zp=1.
  - Reset mid-command abandons it with no partial completion or done.
- IDLE:
  - cmd_ready=1, _0_zp=1.
  - exp_we loads exp<=exp_in; exp_we is ignored in every other state.
  - On cmd_valid: load goes to L_CLR (CLR_T=1) or L_W0 (CLR_T=0); store goes to S_SEL0.
- L_CLR: _0_t=1 for exactly one cycle -> L_W0.
- L_Wn, n=0..2:
  - win_ready=1.
  - On handshake: register w<=win_data; assert lkb=1, f9=0, taa=tab=trb=0.
  - Enables: n=0 opta only, n=1 optb only, n=2 optc only.
  - n=2 additionally latches exp<=win_data[8:15].
  - Go to L_Sn.
- L_Sn:
  - strob_fp=1 for one cycle, win_ready=0.
  - Next state is L_W(n+1); after L_S2, DONE.
  - w, the enables and the select lines hold from acceptance until the next acceptance or DONE, so they are stable across the strob_fp falling edge.
  - Minimum 2 cycles per word; stalls on win_valid are unbounded.
- S_SELn:
  - _0_zp=0; {zpb,zpa} = n (00, 01, 10, 11=flags).
  - Capture wout_data<=zp at the clock edge -> S_OUTn.
  - Word 2 = {T[32:39], exp}.
- S_OUTn:
  - wout_valid=1; wout_data is stable until wout_ready.
  - On handshake: n<2, or n=2 with cmd_flags latched at command accept, -> S_SEL(n+1); otherwise DONE.
  - wout_ready already high when wout_valid rises completes the word in that cycle.
- DONE:
  - done=1 for one cycle.
  - All T control lines are returned to idle values -> IDLE.
  - A back-to-back command is accepted on the following cycle.
- No T modification occurs during store (opt*=0).
- cmd_flags is sampled only at acceptance.

Test Plan:
- Load 0x4000, 0x1234, 0xAB7F with CLR_T=1, win_valid constantly high:
  - _0_t pulse, then 3 strob_fp pulses with opta, optb, optc respectively.
  - w = each word during its strobe; exp=0x7F; done 8 cycles after command accept.
- Store with cmd_flags=0, model zp from T={0x4000,0x1234,0xAB}, exp=0x7F:
  - wout words 0x4000, 0x1234, 0xAB7F; zp select sequence 00, 01, 10; done.
- Store with cmd_flags=1, flags zp=0xA000, wout_ready toggled 1-0-1:
  - 4 words, wout_data stable while stalled, 4th word 0xA000.
- exp_we=1, exp_in=0x55 in IDLE -> exp=d=0x55; exp_we during a load word 1 -> exp unchanged.
- rst_ low during L_S1 -> strob_fp, opt* and win_ready 0 immediately, exp=0, no done; a new load completes normally afterwards.
